// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS F-stage: next-PC encodings, fetch FSM
// states, default fetch addresses, and the fetch-address legality check.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_NONE = 2'b00,
        NPC_BR   = 2'b01,
        NPC_J    = 2'b10,
        NPC_JR   = 2'b11
    } npc_op_t;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_LO_DEFAULT    = 32'h0000_3000;
    localparam logic [31:0] PC_HI_DEFAULT    = 32'h0000_4FFC;

    // Misaligned or outside the legal instruction-memory window.
    function automatic logic pc_illegal(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle between the D-stage / hazard unit (master) and the fetch unit (slave).
interface pc_fetch_unit_if;
    logic        stall;
    logic        redir_v;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc4_d;
    logic [25:0] instr_idx;
    logic [31:0] rs_val;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        redir_pend;
    logic        pc_err;

    modport master (
        output stall, redir_v, npc_op, br_taken, br_target, pc4_d, instr_idx, rs_val,
        input  pc_f, pc4_f, redir_pend, pc_err
    );

    modport slave (
        input  stall, redir_v, npc_op, br_taken, br_target, pc4_d, instr_idx, rs_val,
        output pc_f, pc4_f, redir_pend, pc_err
    );
endinterface

// File: rtl/pc_fetch_unit_npc_target_mux.sv
// Combinational redirect decode: decides whether the D-stage instruction
// really redirects fetch (eff) and where to (tgt). A not-taken branch is
// treated exactly like no redirect.
module npc_target_mux
    import mips_pkg::*;
(
    input  logic        redir_v,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [3:0]  pc4_hi,
    input  logic [25:0] instr_idx,
    input  logic [31:0] rs_val,
    output logic        eff,
    output logic [31:0] tgt
);

    npc_op_t op;
    assign op = npc_op_t'(npc_op);

    // Select the redirect target and qualify the strobe by redirect kind.
    always_comb begin
        eff = 1'b0;
        tgt = '0;
        case (op)
            NPC_BR: begin
                tgt = br_target;
                eff = redir_v & br_taken;
            end
            NPC_J: begin
                tgt = {pc4_hi, instr_idx, 2'b00};
                eff = redir_v;
            end
            NPC_JR: begin
                // jr target is used as-is; misalignment is left visible.
                tgt = rs_val;
                eff = redir_v;
            end
            default: begin
                tgt = '0;
                eff = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// F-stage program counter. Advances by 4 or takes a D-stage redirect; a
// redirect seen during a stall is parked in pend_tgt and applied on release.
// Optional macro PC_BOUNDS_CHECK_EN adds a registered pc_err flag that marks
// misaligned or out-of-window fetch addresses (PC_LO..PC_HI).
//
// state | meaning
// RUN   | normal fetch, no redirect waiting
// PEND  | a redirect was captured under stall and waits for release
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef PC_BOUNDS_CHECK_EN
    ,
    parameter logic [31:0] PC_LO    = PC_LO_DEFAULT,
    parameter logic [31:0] PC_HI    = PC_HI_DEFAULT
`endif
)(
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.slave  bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pend_tgt_q;
    logic         pc_we, pend_we;
    logic         eff;
    logic [31:0]  tgt;

    npc_target_mux u_npc_target_mux (
        .redir_v   (bus.redir_v),
        .npc_op    (bus.npc_op),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .pc4_hi    (bus.pc4_d[31:28]),
        .instr_idx (bus.instr_idx),
        .rs_val    (bus.rs_val),
        .eff       (eff),
        .tgt       (tgt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next state: park on a stalled redirect, leave PEND as soon as the stall drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.stall && eff) state_d = PEND;
            PEND:    if (!bus.stall)       state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Datapath controls: a fresh redirect always beats a parked one.
    always_comb begin
        pc_we   = ~bus.stall;
        pend_we = bus.stall & eff;
        pc_d    = pc_q + 32'd4;
        case (state_q)
            RUN:     if (eff) pc_d = tgt;
            PEND:    pc_d = eff ? tgt : pend_tgt_q;
            default: pc_d = pc_q + 32'd4;
        endcase
    end

    // PC and pending-target registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
        end else begin
            if (pc_we)   pc_q       <= pc_d;
            if (pend_we) pend_tgt_q <= tgt;
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    logic pc_err_q;

    // Flag tracks the legality of whatever address was last loaded into pc_f.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      pc_err_q <= 1'b0;
        else if (pc_we) pc_err_q <= pc_illegal(pc_d, PC_LO, PC_HI);
    end

    assign bus.pc_err = pc_err_q;
`else
    assign bus.pc_err = 1'b0;
`endif

    assign bus.pc_f       = pc_q;
    assign bus.pc4_f      = pc_q + 32'd4;
    assign bus.redir_pend = (state_q == PEND);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit. Each step drives D-stage
// inputs, queues the expected fetch outputs, and checks them just after the edge.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic err_exp = 1'b0;

    function automatic logic pc_bad(input logic [31:0] pc);
`ifdef PC_BOUNDS_CHECK_EN
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_4FFC);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".pc_f"},       bus.pc_f,                 e.pc);
            chk({e.tag, ".pc4_f"},      bus.pc4_f,                e.pc + 32'd4);
            chk({e.tag, ".redir_pend"}, {31'd0, bus.redir_pend},  {31'd0, e.pend});
            chk({e.tag, ".pc_err"},     {31'd0, bus.pc_err},      {31'd0, e.err});
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic pend, input logic err, input string tag);
        exp_t e;
        e.pc = pc; e.pend = pend; e.err = err; e.tag = tag;
        sb.push_back(e);
    endtask

    // One clock of stimulus; pc_err is expected to refresh only when pc_f loads.
    task automatic step(input logic st, input logic rv, input logic [1:0] op,
                        input logic bt, input logic [31:0] btgt, input logic [31:0] p4d,
                        input logic [25:0] idx, input logic [31:0] rs,
                        input logic [31:0] exp_pc, input logic exp_pend, input string tag);
        bus.stall     = st;
        bus.redir_v   = rv;
        bus.npc_op    = op;
        bus.br_taken  = bt;
        bus.br_target = btgt;
        bus.pc4_d     = p4d;
        bus.instr_idx = idx;
        bus.rs_val    = rs;
        if (!st) err_exp = pc_bad(exp_pc);
        push_exp(exp_pc, exp_pend, err_exp, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input logic [31:0] exp_pc, input string tag);
        step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0, exp_pc, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.redir_v = 1'b0; bus.npc_op = 2'b00; bus.br_taken = 1'b0;
        bus.br_target = '0; bus.pc4_d = '0; bus.instr_idx = '0; bus.rs_val = '0;
        #2;
        push_exp(32'h0000_3000, 1'b0, 1'b0, "reset");
        check_out();
        #1 reset = 1'b0;

        idle(32'h0000_3004, "seq1");
        idle(32'h0000_3008, "seq2");
        idle(32'h0000_300C, "seq3");
        idle(32'h0000_3010, "seq4");

        step(0, 1, 2'b01, 1, 32'h0000_3040, 32'h0, 26'h0, 32'h0, 32'h0000_3040, 0, "br_taken");
        step(0, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3010, 32'h0000_3010, 0, "jr_back");
        step(0, 1, 2'b01, 0, 32'h0000_3040, 32'h0, 26'h0, 32'h0, 32'h0000_3014, 0, "br_not_taken");

        step(1, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3100, 32'h0000_3014, 1, "stall_jr_cap");
        step(1, 0, 2'b00, 0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0000_3014, 1, "stall_jr_hold");
        idle(32'h0000_3100, "stall_jr_release");

        step(1, 1, 2'b10, 0, 32'h0, 32'h0000_3024, 26'h0000C40, 32'h0, 32'h0000_3100, 1, "stall_j_cap");
        step(1, 0, 2'b00, 0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0000_3100, 1, "stall_j_hold");
        step(0, 1, 2'b01, 1, 32'h0000_3200, 32'h0, 26'h0, 32'h0, 32'h0000_3200, 0, "fresh_wins");

        step(1, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3300, 32'h0000_3200, 1, "newest_cap1");
        step(1, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3400, 32'h0000_3200, 1, "newest_cap2");
        step(1, 1, 2'b01, 0, 32'h0000_3600, 32'h0, 26'h0, 32'h0, 32'h0000_3200, 1, "pend_nt_branch");
        idle(32'h0000_3400, "newest_applied");

        step(0, 0, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3700, 32'h0000_3404, 0, "no_strobe");
        step(0, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, "jr_top");
        idle(32'h0000_0000, "pc_wrap");
        step(0, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3000, 32'h0000_3000, 0, "jr_home");

        step(1, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3500, 32'h0000_3000, 1, "pend_before_rst");
        bus.stall = 1'b0; bus.redir_v = 1'b0;
        reset = 1'b1;
        #1;
        err_exp = 1'b0;
        push_exp(32'h0000_3000, 1'b0, 1'b0, "async_rst");
        check_out();
        #1 reset = 1'b0;
        idle(32'h0000_3004, "post_rst1");
        idle(32'h0000_3008, "post_rst2");

        step(0, 1, 2'b11, 0, 32'h0, 32'h0, 26'h0, 32'h0000_3002, 32'h0000_3002, 0, "jr_misaligned");
        step(1, 0, 2'b00, 0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0000_3002, 0, "err_held");
        step(0, 1, 2'b10, 0, 32'h0, 32'h0000_3008, 26'h0000C00, 32'h0, 32'h0000_3000, 0, "j_legal");
        idle(32'h0000_3004, "final_seq");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
